ptgen: RTL and testbench

PTGEN -- requirements
Module: ptgen

---
 rtl/ptgen.sv | 122 ++++++++++++
 tb/tb_ptgen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ptgen.sv
`default_nettype none
// ============================================================================
// Module   : ptgen
// Brief    : Digital-to-time pulse generator; a 7-bit width becomes an
//            exactly-that-long high pulse followed by a GAP-cycle low guard.
//            Optional PTGEN_REPEAT_EN turns it into a continuous pulse train.
// Revision : 1.0 - initial release
// ============================================================================
module ptgen #(
   parameter int GAP = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [6:0] i_width,
   input  logic       i_valid,
   output logic       o_ready,
   output logic       o_out,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [6:0] c_gap_load = 7'(GAP - 1);

   state_t     r_state;
   logic [6:0] r_cnt;
   logic       w_start;
   logic [6:0] w_start_width;
   logic       w_gap_rdy_first;

`ifdef PTGEN_REPEAT_EN
   localparam bit c_repeat = 1'b1;

   logic [6:0] r_width;
   logic       w_gap_end;

   // The last GAP cycle either takes a new request or re-arms the last width.
   assign w_gap_end     = (r_state == ST_GAP) && (r_cnt == 7'd0);
   assign w_start       = (i_valid && o_ready) || (w_gap_end && (r_width != 7'd0));
   assign w_start_width = i_valid ? i_width : r_width;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         r_width <= 7'd0;
      else if (w_start)
         r_width <= w_start_width;
   end
`else
   localparam bit c_repeat = 1'b0;

   assign w_start       = i_valid && o_ready;
   assign w_start_width = i_width;
`endif

   assign w_gap_rdy_first = c_repeat && (GAP == 1);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 7'd0;
         o_out   <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
         o_ready <= 1'b1;
      end else begin
         o_done <= 1'b0;
         if (w_start) begin
            o_busy <= 1'b1;
            if (w_start_width != 7'd0) begin
               r_state <= ST_HIGH;
               r_cnt   <= w_start_width;
               o_out   <= 1'b1;
               o_ready <= 1'b0;
            end else begin
               r_state <= ST_GAP;
               r_cnt   <= c_gap_load;
               o_out   <= 1'b0;
               o_done  <= 1'b1;
               o_ready <= w_gap_rdy_first;
            end
         end else begin
            case (r_state)
               ST_IDLE: ;
               ST_HIGH: begin
                  if (r_cnt == 7'd1) begin
                     r_state <= ST_GAP;
                     r_cnt   <= c_gap_load;
                     o_out   <= 1'b0;
                     o_done  <= 1'b1;
                     o_ready <= w_gap_rdy_first;
                  end else begin
                     r_cnt <= r_cnt - 7'd1;
                  end
               end
               ST_GAP: begin
                  if (r_cnt == 7'd0) begin
                     r_state <= ST_IDLE;
                     o_busy  <= 1'b0;
                     o_ready <= 1'b1;
                  end else begin
                     r_cnt   <= r_cnt - 7'd1;
                     o_ready <= c_repeat && (r_cnt == 7'd1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  o_out   <= 1'b0;
                  o_busy  <= 1'b0;
                  o_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ptgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptgen
// Brief    : Directed self-checking bench for ptgen (GAP = 3); outputs are
//            sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptgen;

   localparam int GAP = 3;

   logic       i_clk   = 1'b0;
   logic       i_rst   = 1'b0;
   logic [6:0] i_width = 7'd0;
   logic       i_valid = 1'b0;
   logic       o_ready;
   logic       o_out;
   logic       o_busy;
   logic       o_done;

   int vec_cnt = 0;
   int err_cnt = 0;

   ptgen #(.GAP(GAP)) u_dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_width (i_width),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_out   (o_out),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One request; measures high time, done strobe and GAP length until ready.
   task automatic run_pulse(input logic [6:0] w, input string tag);
      int hi;
      int n;
      i_width = w;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      hi = 0;
      while (o_out && hi < 200) begin
         hi++;
         @(negedge i_clk);
      end
      check({tag, "_high"}, hi, 32'(w));
      check({tag, "_done"}, 32'(o_done), 1);
      check({tag, "_busy"}, 32'(o_busy), 1);
      @(negedge i_clk);
      check({tag, "_done_clr"}, 32'(o_done), 0);
      n = 1;
      while (!o_ready && n < 50) begin
         n++;
         @(negedge i_clk);
      end
      check({tag, "_gap"}, n, GAP);
   endtask

   initial begin : p_main
      logic [31:0] obs;
      int          n;
      int          dn;

      repeat (2) @(negedge i_clk);
      check("rst_ready", 32'(o_ready), 1);
      check("rst_out",   32'(o_out),   0);
      check("rst_busy",  32'(o_busy),  0);
      check("rst_done",  32'(o_done),  0);
      i_rst = 1'b1;
      @(negedge i_clk);

`ifndef PTGEN_REPEAT_EN
      run_pulse(7'd10,  "w10");
      run_pulse(7'd127, "w127");
      run_pulse(7'd1,   "w1");
      run_pulse(7'd0,   "w0");

      // i_valid held high: 5 high / 4 low, width change mid-pulse hits the next one
      obs     = 32'd0;
      i_width = 7'd5;
      i_valid = 1'b1;
      for (int k = 0; k < 24; k++) begin
         @(negedge i_clk);
         obs[k] = o_out;
         if (k == 11) i_width = 7'd2;
      end
      i_valid = 1'b0;
      check("train", obs, 32'h000C3E1F);
      check("train_ready", 32'(o_ready), 1);
      check("train_busy",  32'(o_busy),  0);

      // Reset asserted in the 4th high cycle of a 20-cycle pulse
      i_width = 7'd20;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (3) @(negedge i_clk);
      check("mid_high", 32'(o_out), 1);
      #1 i_rst = 1'b0;
      #1;
      check("mid_out",   32'(o_out),   0);
      check("mid_done",  32'(o_done),  0);
      check("mid_ready", 32'(o_ready), 1);
      check("mid_busy",  32'(o_busy),  0);
      @(negedge i_clk);
      check("mid_done_hold", 32'(o_done), 0);
      i_rst = 1'b1;
      run_pulse(7'd7, "w7_post");
`else
      // Repeat mode: one request of 8 gives an 8-high / 3-low train
      i_width = 7'd8;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      obs = 32'd0;
      dn  = 0;
      for (int k = 0; k < 22; k++) begin
         obs[k] = o_out;
         dn     = dn + int'(o_done);
         @(negedge i_clk);
      end
      check("rep_train", obs, 32'h0007F8FF);
      check("rep_done",  dn,  2);

      n = 0;
      while (!o_ready && n < 30) begin
         n++;
         @(negedge i_clk);
      end
      check("rep_ready", 32'(o_ready), 1);
      i_width = 7'd0;
      i_valid = 1'b1;
      @(negedge i_clk);
      i_valid = 1'b0;
      check("rep_stop_out",  32'(o_out),  0);
      check("rep_stop_done", 32'(o_done), 1);
      repeat (GAP) @(negedge i_clk);
      check("rep_idle_busy",  32'(o_busy),  0);
      check("rep_idle_ready", 32'(o_ready), 1);
      dn = 0;
      repeat (12) begin
         dn = dn + int'(o_out);
         @(negedge i_clk);
      end
      check("rep_quiet", dn, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
